// File: rtl/ex_mem.sv
// Execute-to-memory pipeline register: squashes wrong-path work after a taken
// jump, honours stalls, and exports forwarding / load-use hazard information.
module ex_mem #(
    parameter int PC_W         = 5,
    parameter int DATA_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_write_data,
    input  logic [2:0]        in_jump_type,
    input  logic              in_reg_wrenable,
    input  logic              in_mem_wrenable,
    input  logic [4:0]        in_write_reg,
    input  logic              in_mem_to_reg,
    input  logic              stall,
    input  logic              redirect,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_write_data,
    output logic [2:0]        out_jump_type,
    output logic              out_reg_wrenable,
    output logic              out_mem_wrenable,
    output logic [4:0]        out_write_reg,
    output logic              out_mem_to_reg,
    output logic              fwd_valid,
    output logic [4:0]        fwd_reg,
    output logic              load_hazard,
    output logic              squash_busy,
    output logic [7:0]        squash_count
);

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] write_data;
        logic [2:0]        jump_type;
        logic              reg_wrenable;
        logic              mem_wrenable;
        logic [4:0]        write_reg;
        logic              mem_to_reg;
    } stage_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    stage_t     cur;
    stage_t     incoming;
    logic [2:0] sq_cnt;
    logic [7:0] sq_total;
    logic [7:0] sq_total_inc;

    // An invalid instruction is loaded as an all-zero bubble so its enables are inert.
    always_comb begin
        incoming = '0;
        if (in_valid) begin
            incoming.valid        = 1'b1;
            incoming.pc           = in_pc;
            incoming.alu_res      = in_alu_res;
            incoming.write_data   = in_write_data;
            incoming.jump_type    = in_jump_type;
            incoming.reg_wrenable = in_reg_wrenable;
            incoming.mem_wrenable = in_mem_wrenable;
            incoming.write_reg    = in_write_reg;
            incoming.mem_to_reg   = in_mem_to_reg;
        end
    end

    assign sq_total_inc = (in_valid && sq_total != 8'hFF) ? sq_total + 8'd1 : sq_total;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= '0;
            sq_cnt   <= '0;
            sq_total <= '0;
        end else if (redirect) begin
            cur      <= '0;
            sq_cnt   <= FLUSH_RELOAD;
            sq_total <= sq_total_inc;
        end else if (stall) begin
            cur      <= cur;
            sq_cnt   <= sq_cnt;
            sq_total <= sq_total;
        end else if (sq_cnt != 3'd0) begin
            cur      <= '0;
            sq_cnt   <= sq_cnt - 3'd1;
            sq_total <= sq_total_inc;
        end else begin
            cur      <= incoming;
        end
    end

    assign out_valid        = cur.valid;
    assign out_pc           = cur.pc;
    assign out_alu_res      = cur.alu_res;
    assign out_write_data   = cur.write_data;
    assign out_jump_type    = cur.jump_type;
    assign out_reg_wrenable = cur.reg_wrenable;
    assign out_mem_wrenable = cur.mem_wrenable;
    assign out_write_reg    = cur.write_reg;
    assign out_mem_to_reg   = cur.mem_to_reg;

    // Register 0 is hardwired, so it is never forwarded nor a hazard source.
    assign fwd_valid    = cur.valid & cur.reg_wrenable & ~cur.mem_to_reg & (cur.write_reg != 5'd0);
    assign fwd_reg      = cur.write_reg;
    assign load_hazard  = cur.valid & cur.reg_wrenable & cur.mem_to_reg & (cur.write_reg != 5'd0);
    assign squash_busy  = (sq_cnt != 3'd0);
    assign squash_count = sq_total;

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: streaming, hazards, stalls, squash windows,
// counter saturation and asynchronous reset mid-squash.
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [4:0]  in_pc;
    logic [31:0] in_alu_res;
    logic [31:0] in_write_data;
    logic [2:0]  in_jump_type;
    logic        in_reg_wrenable;
    logic        in_mem_wrenable;
    logic [4:0]  in_write_reg;
    logic        in_mem_to_reg;
    logic        stall;
    logic        redirect;
    logic        out_valid;
    logic [4:0]  out_pc;
    logic [31:0] out_alu_res;
    logic [31:0] out_write_data;
    logic [2:0]  out_jump_type;
    logic        out_reg_wrenable;
    logic        out_mem_wrenable;
    logic [4:0]  out_write_reg;
    logic        out_mem_to_reg;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic        load_hazard;
    logic        squash_busy;
    logic [7:0]  squash_count;

    int errors = 0;
    int checks = 0;

    ex_mem #(.PC_W(5), .DATA_W(32), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_alu_res(in_alu_res),
        .in_write_data(in_write_data), .in_jump_type(in_jump_type),
        .in_reg_wrenable(in_reg_wrenable), .in_mem_wrenable(in_mem_wrenable),
        .in_write_reg(in_write_reg), .in_mem_to_reg(in_mem_to_reg),
        .stall(stall), .redirect(redirect),
        .out_valid(out_valid), .out_pc(out_pc), .out_alu_res(out_alu_res),
        .out_write_data(out_write_data), .out_jump_type(out_jump_type),
        .out_reg_wrenable(out_reg_wrenable), .out_mem_wrenable(out_mem_wrenable),
        .out_write_reg(out_write_reg), .out_mem_to_reg(out_mem_to_reg),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .load_hazard(load_hazard),
        .squash_busy(squash_busy), .squash_count(squash_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ALU-style op: write_reg r, alu_res = r*16, store data derived from r.
    task automatic op(input logic v, input logic [4:0] r, input logic ld);
        in_valid        = v;
        in_pc           = r + 5'd1;
        in_alu_res      = {23'd0, r, 4'h0};
        in_write_data   = 32'hA000_0000 | {27'd0, r};
        in_jump_type    = 3'd1;
        in_reg_wrenable = 1'b1;
        in_mem_wrenable = 1'b0;
        in_write_reg    = r;
        in_mem_to_reg   = ld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0;
        op(1'b0, 5'd0, 1'b0);
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_alu", out_alu_res, 32'd0);
        chk("rst_wreg", 32'(out_write_reg), 32'd0);
        chk("rst_busy", 32'(squash_busy), 32'd0);
        chk("rst_count", 32'(squash_count), 32'd0);
        reset = 1'b0;
        #1;

        // Three back-to-back ALU ops
        for (int i = 1; i <= 3; i++) begin
            op(1'b1, 5'(i), 1'b0);
            step();
            chk("alu_valid", 32'(out_valid), 32'd1);
            chk("alu_res", out_alu_res, 32'(i * 16));
            chk("alu_pc", 32'(out_pc), 32'(i + 1));
            chk("alu_wdata", out_write_data, 32'hA000_0000 | 32'(i));
            chk("alu_fwd", 32'(fwd_valid), 32'd1);
            chk("alu_fwd_reg", 32'(fwd_reg), 32'(i));
            chk("alu_ldhaz", 32'(load_hazard), 32'd0);
        end

        // Load to r5 then load to r0
        op(1'b1, 5'd5, 1'b1); step();
        chk("ld5_haz", 32'(load_hazard), 32'd1);
        chk("ld5_fwd", 32'(fwd_valid), 32'd0);
        op(1'b1, 5'd0, 1'b1); step();
        chk("ld0_haz", 32'(load_hazard), 32'd0);
        chk("ld0_fwd", 32'(fwd_valid), 32'd0);
        op(1'b1, 5'd0, 1'b0); step();
        chk("alu0_fwd", 32'(fwd_valid), 32'd0);

        // Invalid input becomes a zeroed bubble
        op(1'b0, 5'd6, 1'b0); step();
        chk("bub_valid", 32'(out_valid), 32'd0);
        chk("bub_alu", out_alu_res, 32'd0);
        chk("bub_wren", 32'(out_reg_wrenable), 32'd0);
        chk("bub_jt", 32'(out_jump_type), 32'd0);

        // Stall holds for two edges
        op(1'b1, 5'd7, 1'b0); step();
        chk("st_pre", 32'(out_write_reg), 32'd7);
        op(1'b1, 5'd8, 1'b0); stall = 1'b1;
        step(); chk("st_hold1", 32'(out_write_reg), 32'd7);
        step(); chk("st_hold2", out_alu_res, 32'h70);
        stall = 1'b0;
        step(); chk("st_rel", 32'(out_write_reg), 32'd8);

        // Redirect with ops streaming: two bubbles, third op passes
        op(1'b1, 5'd9, 1'b0); redirect = 1'b1; step();
        chk("rd_v0", 32'(out_valid), 32'd0);
        chk("rd_busy0", 32'(squash_busy), 32'd1);
        chk("rd_cnt0", 32'(squash_count), 32'd1);
        redirect = 1'b0; op(1'b1, 5'd10, 1'b0); step();
        chk("rd_v1", 32'(out_valid), 32'd0);
        chk("rd_busy1", 32'(squash_busy), 32'd0);
        chk("rd_cnt1", 32'(squash_count), 32'd2);
        op(1'b1, 5'd11, 1'b0); step();
        chk("rd_v2", 32'(out_valid), 32'd1);
        chk("rd_wreg2", 32'(out_write_reg), 32'd11);
        chk("rd_cnt2", 32'(squash_count), 32'd2);

        // Redirect together with stall, stall held one more cycle
        op(1'b1, 5'd12, 1'b0); redirect = 1'b1; stall = 1'b1; step();
        chk("rs_v0", 32'(out_valid), 32'd0);
        chk("rs_busy0", 32'(squash_busy), 32'd1);
        chk("rs_cnt0", 32'(squash_count), 32'd3);
        redirect = 1'b0; step();
        chk("rs_v1", 32'(out_valid), 32'd0);
        chk("rs_busy1", 32'(squash_busy), 32'd1);
        chk("rs_cnt1", 32'(squash_count), 32'd3);
        stall = 1'b0; op(1'b1, 5'd13, 1'b0); step();
        chk("rs_v2", 32'(out_valid), 32'd0);
        chk("rs_busy2", 32'(squash_busy), 32'd0);
        chk("rs_cnt2", 32'(squash_count), 32'd4);
        op(1'b1, 5'd14, 1'b0); step();
        chk("rs_v3", 32'(out_valid), 32'd1);
        chk("rs_wreg3", 32'(out_write_reg), 32'd14);

        // Invalid input during squash window is not counted
        op(1'b0, 5'd3, 1'b0); redirect = 1'b1; step();
        chk("rinv_cnt", 32'(squash_count), 32'd4);
        redirect = 1'b0; step();
        chk("rinv_busy", 32'(squash_busy), 32'd0);

        // Asynchronous reset in the middle of a squash window
        op(1'b1, 5'd14, 1'b0); step();
        op(1'b1, 5'd15, 1'b0); redirect = 1'b1; step();
        chk("ar_busy_pre", 32'(squash_busy), 32'd1);
        chk("ar_cnt_pre", 32'(squash_count), 32'd5);
        redirect = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("ar_busy", 32'(squash_busy), 32'd0);
        chk("ar_cnt", 32'(squash_count), 32'd0);
        chk("ar_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        op(1'b1, 5'd16, 1'b0); step();
        chk("ar_next_v", 32'(out_valid), 32'd1);
        chk("ar_next_wreg", 32'(out_write_reg), 32'd16);

        // Saturation of the squash counter at 255
        op(1'b1, 5'd1, 1'b0); redirect = 1'b1;
        for (int i = 0; i < 254; i++) step();
        chk("sat_254", 32'(squash_count), 32'd254);
        step(); chk("sat_255", 32'(squash_count), 32'd255);
        step(); step();
        chk("sat_hold", 32'(squash_count), 32'd255);
        redirect = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
